// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between NREQ cache ports, the arbiter and the single memory port.
// The arbiter takes the slave view; caches/memory (or a bench) take the master view.
interface cache_mem_arbiter_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [NREQ-1:0]        req_ren;
  logic [NREQ-1:0]        req_wen;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*WORD_W-1:0] req_store;
  logic [NREQ-1:0]        req_wait;
  logic [NREQ*WORD_W-1:0] req_load;
  logic                   mem_ren;
  logic                   mem_wen;
  logic [ADDR_W-1:0]      mem_addr;
  logic [WORD_W-1:0]      mem_store;
  logic [WORD_W-1:0]      mem_load;
  logic                   mem_ready;
  logic                   timeout_err;

  modport slave (
    input  req_ren, req_wen, req_addr, req_store, mem_load, mem_ready,
    output req_wait, req_load, mem_ren, mem_wen, mem_addr, mem_store, timeout_err
  );

  modport master (
    output req_ren, req_wen, req_addr, req_store, mem_load, mem_ready,
    input  req_wait, req_load, mem_ren, mem_wen, mem_addr, mem_store, timeout_err
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// N-requester L1-cache to memory arbiter: one grant at a time, held until the
// memory completes, the requester withdraws, or the optional watchdog expires.
module cache_mem_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned TIMEOUT   = 0
) (
  input logic              CLK,
  input logic              RST,
  cache_mem_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    g_q, g_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NREQ-1:0]        active;
  logic                   found;
  logic [IDX_W-1:0]       win;
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       g_next;
  logic [NREQ-1:0]        wait_c;
  logic [NREQ*WORD_W-1:0] load_c;
  logic                   mem_ren_c, mem_wen_c, tmo_c;
  logic [ADDR_W-1:0]      mem_addr_c;
  logic [WORD_W-1:0]      mem_store_c;

  assign active = bus.req_ren | bus.req_wen;
  assign g_next = (g_q == IDX_W'(NREQ - 1)) ? '0 : g_q + 1'b1;

  // Winner search: rotating start at ptr_q, or fixed start at index 0.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (PRIO_MODE == 0) cand = IDX_W'((32'(ptr_q) + k) % NREQ);
      else                cand = IDX_W'(k);
      if (!found && active[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    wait_c      = active;
    load_c      = '0;
    mem_ren_c   = 1'b0;
    mem_wen_c   = 1'b0;
    mem_addr_c  = '0;
    mem_store_c = '0;
    tmo_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          g_d     = win;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        load_c[g_q*WORD_W +: WORD_W] = bus.mem_load;
        if (!active[g_q]) begin
          // Withdrawn request wins over a coincident mem_ready.
          state_d = IDLE;
          ptr_d   = g_next;
        end else begin
          mem_wen_c   = bus.req_wen[g_q];
          mem_ren_c   = bus.req_ren[g_q] & ~bus.req_wen[g_q];
          mem_addr_c  = bus.req_addr[g_q*ADDR_W +: ADDR_W];
          mem_store_c = bus.req_store[g_q*WORD_W +: WORD_W];
          if (bus.mem_ready) begin
            wait_c[g_q] = 1'b0;
            state_d     = IDLE;
            ptr_d       = g_next;
          end else if (TIMEOUT != 0 && 32'(cnt_q) == TIMEOUT - 1) begin
            tmo_c   = 1'b1;
            state_d = IDLE;
            ptr_d   = g_next;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_wait    = wait_c;
  assign bus.req_load    = load_c;
  assign bus.mem_ren     = mem_ren_c;
  assign bus.mem_wen     = mem_wen_c;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_store   = mem_store_c;
  assign bus.timeout_err = tmo_c;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench: round-robin/watchdog and fixed-priority instances share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_cache_mem_arbiter;
  localparam int N = 2;
  localparam int W = 32;
  localparam int A = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [N-1:0]   ren, wen;
  logic [N*A-1:0] addr;
  logic [N*W-1:0] store;
  logic [W-1:0]   mload;
  logic           mready;

  cache_mem_arbiter_if #(.NREQ(N), .WORD_W(W), .ADDR_W(A)) ifa ();
  cache_mem_arbiter_if #(.NREQ(N), .WORD_W(W), .ADDR_W(A)) ifb ();

  assign ifa.req_ren = ren;   assign ifb.req_ren = ren;
  assign ifa.req_wen = wen;   assign ifb.req_wen = wen;
  assign ifa.req_addr = addr; assign ifb.req_addr = addr;
  assign ifa.req_store = store; assign ifb.req_store = store;
  assign ifa.mem_load = mload;  assign ifb.mem_load = mload;
  assign ifa.mem_ready = mready; assign ifb.mem_ready = mready;

  cache_mem_arbiter #(.NREQ(N), .WORD_W(W), .ADDR_W(A), .PRIO_MODE(0), .TIMEOUT(4))
    dut_rr (.CLK(CLK), .RST(RST), .bus(ifa));
  cache_mem_arbiter #(.NREQ(N), .WORD_W(W), .ADDR_W(A), .PRIO_MODE(1), .TIMEOUT(0))
    dut_fp (.CLK(CLK), .RST(RST), .bus(ifb));

  logic [N-1:0]   o_wait[2];
  logic [N*W-1:0] o_load[2];
  logic           o_ren[2], o_wen[2], o_tmo[2];
  logic [A-1:0]   o_addr[2];
  logic [W-1:0]   o_store[2];
  assign o_wait[0] = ifa.req_wait;   assign o_wait[1] = ifb.req_wait;
  assign o_load[0] = ifa.req_load;   assign o_load[1] = ifb.req_load;
  assign o_ren[0] = ifa.mem_ren;     assign o_ren[1] = ifb.mem_ren;
  assign o_wen[0] = ifa.mem_wen;     assign o_wen[1] = ifb.mem_wen;
  assign o_tmo[0] = ifa.timeout_err; assign o_tmo[1] = ifb.timeout_err;
  assign o_addr[0] = ifa.mem_addr;   assign o_addr[1] = ifb.mem_addr;
  assign o_store[0] = ifa.mem_store; assign o_store[1] = ifb.mem_store;

  int errors = 0;
  int checks = 0;

  // Transaction model: who owns memory, where the rotation resumes, how long it has waited.
  int prio_m[2] = '{0, 1};
  int tlim_m[2] = '{4, 0};
  bit m_busy[2];
  int m_owner[2], m_ptr[2], m_age[2];

  task automatic chk(input string tag, input int inst, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s inst%0d got=%0h exp=%0h", tag, inst, got, exp);
    end
  endtask

  function automatic int pick(input int inst);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (prio_m[inst] != 0) ? k : (m_ptr[inst] + k) % N;
      if (ren[i] | wen[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit live_f(input int inst);
    int o;
    o = m_owner[inst];
    return m_busy[inst] && (ren[o] | wen[o]);
  endfunction

  function automatic bit tmo_f(input int inst);
    return live_f(inst) && !mready && tlim_m[inst] > 0 && m_age[inst] == tlim_m[inst] - 1;
  endfunction

  task automatic check_all();
    for (int inst = 0; inst < 2; inst++) begin
      int o;
      bit lv, dn;
      logic [N-1:0]   e_wait;
      logic [N*W-1:0] e_load;
      o  = m_owner[inst];
      lv = live_f(inst);
      dn = lv && mready;
      for (int i = 0; i < N; i++) e_wait[i] = (ren[i] | wen[i]) && !(dn && i == o);
      e_load = '0;
      if (m_busy[inst]) e_load[o*W +: W] = mload;
      chk("mem_ren", inst, o_ren[inst], lv ? (ren[o] & ~wen[o]) : 1'b0);
      chk("mem_wen", inst, o_wen[inst], lv ? wen[o] : 1'b0);
      chk("mem_addr", inst, o_addr[inst], lv ? addr[o*A +: A] : '0);
      chk("mem_store", inst, o_store[inst], lv ? store[o*W +: W] : '0);
      chk("req_wait", inst, o_wait[inst], e_wait);
      chk("req_load", inst, o_load[inst], e_load);
      chk("timeout_err", inst, o_tmo[inst], tmo_f(inst));
    end
  endtask

  task automatic update();
    for (int inst = 0; inst < 2; inst++) begin
      if (RST) begin
        m_busy[inst] = 0; m_owner[inst] = 0; m_ptr[inst] = 0; m_age[inst] = 0;
      end else if (!m_busy[inst]) begin
        int w;
        w = pick(inst);
        if (w >= 0) begin
          m_busy[inst] = 1; m_owner[inst] = w; m_age[inst] = 0;
        end
      end else if (!live_f(inst) || mready || tmo_f(inst)) begin
        m_busy[inst] = 0;
        m_ptr[inst]  = (m_owner[inst] + 1) % N;
      end else begin
        m_age[inst]++;
      end
    end
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge CLK);
    update();
    @(negedge CLK);
  endtask

  initial begin
    int g1a, g1b;
    ren = '0; wen = '0; addr = '0; store = '0; mload = '0; mready = 1'b0;
    RST = 1'b1;
    @(posedge CLK);
    update();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_mem_ren", 0, ifa.mem_ren, 1'b0);
    chk("rst_wait", 1, ifb.req_wait, 2'b00);

    // Single read by requester 1
    ren[1] = 1'b1; addr[A +: A] = 32'h100;
    step();
    #1;
    chk("t1_ren", 0, ifa.mem_ren, 1'b1);
    chk("t1_addr", 0, ifa.mem_addr, 32'h100);
    chk("t1_wait_busy", 0, ifa.req_wait[1], 1'b1);
    step();
    mready = 1'b1; mload = 32'hDEADBEEF;
    #1;
    chk("t1_wait_done", 0, ifa.req_wait[1], 1'b0);
    chk("t1_load", 0, ifa.req_load[W +: W], 32'hDEADBEEF);
    step();
    ren = '0; mready = 1'b0;
    step();

    // Contention, memory always ready
    ren = 2'b11; addr[0 +: A] = 32'h200; addr[A +: A] = 32'h300; mready = 1'b1;
    g1a = 0; g1b = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ifa.mem_ren && ifa.mem_addr == 32'h300) g1a++;
      if (ifb.mem_ren && ifb.mem_addr == 32'h300) g1b++;
      step();
    end
    chk("rr_grants1", 0, 32'(g1a), 32'd2);
    chk("fp_grants1_contended", 1, 32'(g1b), 32'd0);
    ren[0] = 1'b0;
    g1b = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (ifb.mem_ren && ifb.mem_addr == 32'h300) g1b++;
      step();
    end
    chk("fp_grant1_after_drop", 1, 32'(g1b != 0), 32'd1);
    ren = '0; mready = 1'b0;
    step(); step();

    // Write with both enables
    ren[0] = 1'b1; wen[0] = 1'b1; addr[0 +: A] = 32'h40; store[0 +: W] = 32'h12345678;
    step();
    #1;
    chk("t4_wen", 0, ifa.mem_wen, 1'b1);
    chk("t4_ren", 0, ifa.mem_ren, 1'b0);
    chk("t4_store", 0, ifa.mem_store, 32'h12345678);
    chk("t4_addr", 1, ifb.mem_addr, 32'h40);
    mready = 1'b1;
    step();
    ren = '0; wen = '0; mready = 1'b0;
    step();

    // Abort by requester 1
    ren[1] = 1'b1; addr[A +: A] = 32'h380;
    step(); step();
    ren[1] = 1'b0; mready = 1'b1;
    #1;
    chk("abort_ren", 0, ifa.mem_ren, 1'b0);
    chk("abort_addr", 1, ifb.mem_addr, 32'h0);
    step();

    // Reset mid-transaction
    mready = 1'b0; ren[0] = 1'b1;
    step(); step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    chk("rst_busy_ren", 0, ifa.mem_ren, 1'b0);
    chk("rst_busy_addr", 1, ifb.mem_addr, 32'h0);
    chk("rst_busy_wait", 0, ifa.req_wait, 2'b01);
    ren = '0;
    step();

    // Watchdog on the round-robin instance
    ren = 2'b11; addr[0 +: A] = 32'h500; addr[A +: A] = 32'h600; mready = 1'b0;
    step();
    step(); step(); step();
    #1;
    chk("wd_pulse", 0, ifa.timeout_err, 1'b1);
    chk("wd_wait", 0, ifa.req_wait, 2'b11);
    step();
    #1;
    chk("wd_idle", 0, ifa.timeout_err, 1'b0);
    chk("wd_idle_ren", 0, ifa.mem_ren, 1'b0);
    step();
    #1;
    chk("wd_next_grant", 0, ifa.mem_addr, 32'h600);
    step();
    ren = '0;
    step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) begin
          ren[i] = 1'($urandom_range(1));
          wen[i] = ($urandom_range(3) == 0);
          addr[i*A +: A] = $urandom;
          store[i*W +: W] = $urandom;
        end
      end
      mready = 1'($urandom_range(1));
      mload  = $urandom;
      RST    = ($urandom_range(63) == 0);
      step();
    end
    RST = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Parametrised N-requester arbiter between L1 caches and the single memory/bus port, generalising the fixed icache/dcache pair. It accepts independent read/write requests (REN/WEN, addr, store) from NREQ cache ports, grants one at a time, and holds the grant until memory completes or the requester withdraws. Default configuration is NREQ=2 (index 0 = dcache, index 1 = icache). Supports round-robin or fixed-priority mode and a per-transaction watchdog.

Parameters:
NREQ, 2, number of requester ports (>=2)
WORD_W, 32, data word width
ADDR_W, 32, address width
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
TIMEOUT, 0, max BUSY cycles before forced release; 0 disables watchdog

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous active-high reset
req_ren  input  NREQ  per-requester read enable
req_wen  input  NREQ  per-requester write enable
req_addr  input  NREQ*ADDR_W  per-requester address, slice i = [i*ADDR_W +: ADDR_W]
req_store  input  NREQ*WORD_W  per-requester write data
req_wait  output  NREQ  1 = request pending, not completed this cycle
req_load  output  NREQ*WORD_W  read data; slice i valid when req_wait[i]=0 and req_ren[i]=1
mem_ren  output  1  memory read enable
mem_wen  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_store  output  WORD_W  memory write data
mem_load  input  WORD_W  memory read data
mem_ready  input  1  memory completes current access this cycle
timeout_err  output  1  one-cycle pulse on watchdog release

Behaviour:
- Request i is active when req_ren[i] | req_wen[i]. If both are set, the request is a write: mem_wen=1, mem_ren=0.
- FSM states: IDLE and BUSY. Registered state: grant index g, round-robin pointer ptr, BUSY cycle counter.
- IDLE: mem_ren, mem_wen, mem_addr and mem_store are all 0.
  - If any request is active, choose a winner and register g; next state is BUSY.
  - PRIO_MODE=0: winner is the first active index scanning ptr, ptr+1, ... modulo NREQ.
  - PRIO_MODE=1: winner is the lowest active index.
  - If no request is active, stay in IDLE.
- BUSY: mem_* outputs are driven combinationally from requester g's live inputs. Requesters must hold addr, store and enables stable while waiting.
  - When mem_ready=1: req_wait[g]=0 in the same cycle, and req_load slice g = mem_load. Next state is IDLE; ptr <= (g+1) mod NREQ.
  - If requester g deasserts both enables (abort): mem_* drop to 0 that cycle, mem_ready is ignored, next state is IDLE, ptr <= (g+1) mod NREQ.
- Latency: one arbitration cycle (IDLE) precedes every access. Minimum turnaround is 2 cycles from request to completion, and there is a 1-cycle bubble between back-to-back grants.
- req_wait[i] = active(i) & ~(state==BUSY & g==i & mem_ready). Non-granted active requesters always see wait=1; inactive requesters see 0.
- req_load: slice g carries mem_load; all other slices are 0.
- Watchdog (TIMEOUT>0):
  - The counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - When the counter reaches TIMEOUT-1 and mem_ready=0: timeout_err=1 for that cycle, req_wait[g] stays 1, next state is IDLE, ptr advances past g.
- Simultaneous events:
  - mem_ready takes precedence over the watchdog in the same cycle.
  - Abort takes precedence over mem_ready.
  - New requests arriving in the completion cycle are arbitrated in the following IDLE cycle.
- Reset (RST=1 at a clock edge, including mid-transaction): state=IDLE, g=0, ptr=0, counter=0, timeout_err=0. Any in-flight access is dropped.
  - mem_ren, mem_wen, mem_addr and mem_store are 0 from the first cycle after reset.
  - req_wait reflects active requests (wait=1 for each active requester).
- Address and data pass through unchanged. No width conversion: each slice is exactly ADDR_W or WORD_W bits.

Test Plan:
1. Single read, NREQ=2: req_ren[1]=1, addr 0x100; mem_ready=1 two cycles later, mem_load=0xDEADBEEF -> mem_ren=1 with mem_addr=0x100 in BUSY; req_wait[1]=0 and req_load slice 1 = 0xDEADBEEF in the ready cycle; req_wait[1]=1 before that.
2. Round-robin contention, PRIO_MODE=0, both requesters active continuously, mem_ready=1 on every BUSY cycle -> grants alternate 0,1,0,1. req_wait of the loser stays 1 throughout.
3. Fixed priority, PRIO_MODE=1, both active -> requester 0 is granted every time; requester 1 is granted only after req_ren[0] drops.
4. Write with both enables set: req_ren[0]=req_wen[0]=1, store 0x12345678, addr 0x40 -> mem_wen=1, mem_ren=0, mem_store=0x12345678, mem_addr=0x40.
5. Abort and reset: requester 1 drops its enables mid-BUSY -> mem_* become 0 the same cycle and the FSM returns to IDLE. Separately, RST asserted mid-BUSY -> all mem_* are 0 the next cycle and ptr=0.
6. Watchdog, TIMEOUT=4, mem_ready held 0 -> timeout_err pulses on the 4th BUSY cycle. With the other requester active, that requester is granted after the following IDLE cycle.
